// File: rtl/clock_mode_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_mode_sched_pkg
// Description : Shared types and constants for the clock mode scheduler:
//               mode / position encodings, pushbutton bit indices and the
//               mode sequencing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_mode_sched_pkg;

    // Operating mode, kept as plain 2-bit localparams for legacy compatibility
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_CLOCK = 2'd0;
    localparam mode_t MODE_SETUP = 2'd1;
    localparam mode_t MODE_ALARM = 2'd2;
    localparam mode_t MODE_RSVD  = 2'd3;

    // Edit position
    typedef logic pos_t;
    localparam pos_t POS_SEC = 1'b0;
    localparam pos_t POS_MIN = 1'b1;

    // Pushbutton bit positions within i_sw
    localparam int SW_MODE  = 0;
    localparam int SW_POS   = 1;
    localparam int SW_INC   = 2;
    localparam int SW_ALM   = 3;
    localparam int SW_COUNT = 4;

    // CLOCK -> SETUP -> ALARM -> CLOCK; the reserved code also lands on CLOCK
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_CLOCK: return MODE_SETUP;
            MODE_SETUP: return MODE_ALARM;
            default:    return MODE_CLOCK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_mode_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_mode_sched_if
// Description : Button inputs and counter-enable outputs of the clock mode
//               scheduler. master = stimulus / surrounding logic side,
//               slave = scheduler side.
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_mode_sched_if;
    import clock_mode_sched_pkg::*;

    logic [SW_COUNT-1:0] i_sw;
    logic                i_sec_at_max;
    mode_t               o_mode;
    pos_t                o_position;
    logic                o_alarm_en;
    logic                o_sec_en;
    logic                o_min_en;
    logic                o_alarm_sec_en;
    logic                o_alarm_min_en;
    logic                o_tick;

    modport master (
        output i_sw, i_sec_at_max,
        input  o_mode, o_position, o_alarm_en, o_sec_en, o_min_en,
               o_alarm_sec_en, o_alarm_min_en, o_tick
    );

    modport slave (
        input  i_sw, i_sec_at_max,
        output o_mode, o_position, o_alarm_en, o_sec_en, o_min_en,
               o_alarm_sec_en, o_alarm_min_en, o_tick
    );

endinterface
`default_nettype wire

// File: rtl/clock_mode_sched_sw_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : sw_conditioner
// Description : One pushbutton: 2-flop synchronizer, stable-level debounce
//               (DEB_CYCLES consecutive differing samples to accept a new
//               level) and a one-cycle pulse on an accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_conditioner #(
    parameter int DEB_CYCLES = 500000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_raw,
    output logic      o_level,
    output logic      o_press
);

    localparam int                 c_cnt_w   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level after it has differed for DEB_CYCLES samples; the
    // press pulse is raised on the same edge the accepted level rises
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_level <= r_sync2;
                r_press <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/clock_mode_sched.sv
`default_nettype none
// ============================================================================
// Module      : clock_mode_sched
// Description : Mode scheduler for the digital clock min/sec datapath.
//               Conditions four pushbuttons, runs the CLOCK/SETUP/ALARM mode
//               FSM, generates the 1 Hz tick and issues one-cycle enables to
//               the time and alarm counters (all counters stay on clk).
//               Optional build macro: CLOCK_MODE_SCHED_AUTO_REPEAT_EN adds
//               auto-repeat of a held increment button in SETUP / ALARM.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_mode_sched
    import clock_mode_sched_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int DEB_CYCLES    = 500000,
    parameter int REPEAT_DLY    = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input wire logic           clk,
    input wire logic           rst,
    clock_mode_sched_if.slave  bus
);

    localparam int                 c_pre_w   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(CLK_HZ - 1);
    localparam logic [c_pre_w-1:0] c_pre_one = c_pre_w'(1);

    logic [SW_COUNT-1:0] w_level;
    logic [SW_COUNT-1:0] w_press;
    logic                w_mode_press;
    logic                w_pos_press;
    logic                w_alm_press;
    logic                w_inc_press;
    logic                w_inc_ok;
    logic                w_rpt_pulse;
    logic                w_edit_mode;
    logic                w_run_mode;
    logic                w_tick;
    logic                w_unused_level;

    mode_t               r_mode;
    pos_t                r_pos;
    logic                r_alarm_en;
    logic [c_pre_w-1:0]  r_presc;
    logic                r_sec_en;
    logic                r_min_en;
    logic                r_alarm_sec_en;
    logic                r_alarm_min_en;

    // One conditioner per pushbutton
    for (genvar gi = 0; gi < SW_COUNT; gi++) begin : g_sw
        sw_conditioner #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_cond (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (bus.i_sw[gi]),
            .o_level (w_level[gi]),
            .o_press (w_press[gi])
        );
    end

    // Only the increment level feeds auto-repeat; the rest are intentionally idle
    assign w_unused_level = ^w_level;

    assign w_mode_press = w_press[SW_MODE];
    assign w_pos_press  = w_press[SW_POS];
    assign w_alm_press  = w_press[SW_ALM];
    assign w_edit_mode  = (r_mode == MODE_SETUP) || (r_mode == MODE_ALARM);
    assign w_run_mode   = (r_mode == MODE_CLOCK) || (r_mode == MODE_ALARM);
    assign w_tick       = (r_presc == c_pre_max) && (r_mode != MODE_SETUP);

`ifdef CLOCK_MODE_SCHED_AUTO_REPEAT_EN
    localparam int                 c_rpt_top = (REPEAT_DLY > REPEAT_PERIOD) ? REPEAT_DLY : REPEAT_PERIOD;
    localparam int                 c_rpt_w   = (c_rpt_top > 1) ? $clog2(c_rpt_top) : 1;
    localparam logic [c_rpt_w-1:0] c_dly_max = c_rpt_w'(REPEAT_DLY - 1);
    localparam logic [c_rpt_w-1:0] c_per_max = c_rpt_w'(REPEAT_PERIOD - 1);
    localparam logic [c_rpt_w-1:0] c_rpt_one = c_rpt_w'(1);

    logic [c_rpt_w-1:0] r_rpt_cnt;
    logic               r_rpt_armed;
    logic               w_rpt_hold;

    assign w_rpt_hold  = w_edit_mode && w_level[SW_INC] && !w_mode_press;
    assign w_rpt_pulse = w_rpt_hold &&
                         (r_rpt_armed ? (r_rpt_cnt == c_per_max) : (r_rpt_cnt == c_dly_max));

    // Hold timer: first repeat after REPEAT_DLY, then every REPEAT_PERIOD;
    // cleared on release, on leaving the edit modes and on a mode press
    always_ff @(posedge clk) begin
        if (rst || !w_rpt_hold) begin
            r_rpt_cnt   <= '0;
            r_rpt_armed <= 1'b0;
        end else if (w_rpt_pulse) begin
            r_rpt_cnt   <= '0;
            r_rpt_armed <= 1'b1;
        end else begin
            r_rpt_cnt   <= r_rpt_cnt + c_rpt_one;
        end
    end
`else
    localparam int c_unused_rpt = REPEAT_DLY + REPEAT_PERIOD;
    assign w_rpt_pulse = 1'b0;
`endif

    assign w_inc_press = w_press[SW_INC] | w_rpt_pulse;
    // A mode press in the same cycle swallows the increment
    assign w_inc_ok    = w_inc_press && !w_mode_press;

    // 1 Hz prescaler, parked at zero while setting the time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (r_mode == MODE_SETUP || r_presc == c_pre_max) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_pre_one;
        end
    end

    // Mode FSM, edit position and alarm arm flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= MODE_CLOCK;
            r_pos      <= POS_SEC;
            r_alarm_en <= 1'b0;
        end else begin
            if (w_mode_press || r_mode == MODE_RSVD) begin
                r_mode <= next_mode(r_mode);
                r_pos  <= POS_SEC;
            end else if (w_pos_press && w_edit_mode) begin
                r_pos  <= ~r_pos;
            end
            if (w_alm_press) begin
                r_alarm_en <= ~r_alarm_en;
            end
        end
    end

    // Registered counter enables from the tick and from increment presses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec_en       <= 1'b0;
            r_min_en       <= 1'b0;
            r_alarm_sec_en <= 1'b0;
            r_alarm_min_en <= 1'b0;
        end else begin
            r_sec_en       <= (w_run_mode && w_tick) ||
                              (r_mode == MODE_SETUP && w_inc_ok && r_pos == POS_SEC);
            r_min_en       <= (w_run_mode && w_tick && bus.i_sec_at_max) ||
                              (r_mode == MODE_SETUP && w_inc_ok && r_pos == POS_MIN);
            r_alarm_sec_en <= (r_mode == MODE_ALARM) && w_inc_ok && (r_pos == POS_SEC);
            r_alarm_min_en <= (r_mode == MODE_ALARM) && w_inc_ok && (r_pos == POS_MIN);
        end
    end

    assign bus.o_mode         = r_mode;
    assign bus.o_position     = r_pos;
    assign bus.o_alarm_en     = r_alarm_en;
    assign bus.o_sec_en       = r_sec_en;
    assign bus.o_min_en       = r_min_en;
    assign bus.o_alarm_sec_en = r_alarm_sec_en;
    assign bus.o_alarm_min_en = r_alarm_min_en;
    assign bus.o_tick         = w_tick;

endmodule
`default_nettype wire
